// File: rtl/mem_writer.sv
// mem_writer: write-side sequencer for the 6502 core.
// Accepts one store request (store byte, push byte, push word, push interrupt frame),
// drives the memory write port one byte per cycle, then reports the new stack pointer.
//
// Optional feature macro: MEM_WRITER_BFLAG_EN
//   defined   : pushed P byte in mode 11 has bit5 forced to 1 and bit4 = brk
//   undefined : P pushed verbatim, brk ignored
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start, mode           request strobe (sampled in IDLE only) and request kind
//   addr_in, data_in      store target / byte (modes 00, 01)
//   word_in, status_in    PC and P for push word / interrupt frame
//   brk                   break source for the interrupt frame P byte
//   sp_in                 current stack pointer
//   addr_out, data_out    memory write address/data (hold when we_mem is low)
//   we_mem                memory write enable, one cycle per byte
//   sp_out, we_sp         updated stack pointer and its load strobe
//   busy, done            request in progress / one-cycle completion pulse
module mem_writer #(
   parameter int unsigned REG_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [REG_WIDTH-1:0]  data_in,
   input  logic [15:0]           word_in,
   input  logic [REG_WIDTH-1:0]  status_in,
   input  logic                  brk,
   input  logic [REG_WIDTH-1:0]  sp_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic [REG_WIDTH-1:0]  data_out,
   output logic                  we_mem,
   output logic [REG_WIDTH-1:0]  sp_out,
   output logic                  we_sp,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {StIdle, StWr0, StWr1, StWr2, StDone} state_e;

   state_e state_q, state_d;

   // Latched request
   logic [1:0]            mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [REG_WIDTH-1:0]  data_q, data_d;
   logic [15:0]           word_q, word_d;
   logic [REG_WIDTH-1:0]  status_q, status_d;
   logic                  brk_q, brk_d;
   logic [REG_WIDTH-1:0]  sp_q, sp_d;

   // Registered outputs
   logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
   logic [REG_WIDTH-1:0]  data_out_q, data_out_d;
   logic                  we_mem_q, we_mem_d;
   logic [REG_WIDTH-1:0]  sp_out_q, sp_out_d;
   logic                  we_sp_q, we_sp_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // Request view: live inputs while accepting in IDLE, latched copy afterwards, so the
   // first byte can be registered on the same edge that samples start.
   logic [1:0]            cur_mode;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [REG_WIDTH-1:0]  cur_data;
   logic [15:0]           cur_word;
   logic [REG_WIDTH-1:0]  cur_status;
   logic                  cur_brk;
   logic [REG_WIDTH-1:0]  cur_sp;

   logic [1:0]            byte_idx;
   logic [1:0]            byte_cnt;
   logic [REG_WIDTH-1:0]  p_byte;
   logic [REG_WIDTH-1:0]  push_sp;
   logic [ADDR_WIDTH-1:0] byte_addr;
   logic [REG_WIDTH-1:0]  byte_data;

`ifdef MEM_WRITER_BFLAG_EN
   assign brk_d = (state_q == StIdle && start) ? brk : brk_q;
`else
   logic unused_brk;
   assign unused_brk = brk;
   assign brk_d      = brk_q;
`endif

   always_comb begin
      if (state_q == StIdle) begin
         cur_mode   = mode;
         cur_addr   = addr_in;
         cur_data   = data_in;
         cur_word   = word_in;
         cur_status = status_in;
         cur_brk    = brk;
         cur_sp     = sp_in;
      end else begin
         cur_mode   = mode_q;
         cur_addr   = addr_q;
         cur_data   = data_q;
         cur_word   = word_q;
         cur_status = status_q;
         cur_brk    = brk_q;
         cur_sp     = sp_q;
      end
   end

   // Index of the byte to be emitted on the coming edge.
   always_comb begin
      case (state_q)
         StWr0:   byte_idx = 2'd1;
         StWr1:   byte_idx = 2'd2;
         default: byte_idx = 2'd0;
      endcase
   end

   always_comb begin
      case (cur_mode)
         2'b10:   byte_cnt = 2'd2;
         2'b11:   byte_cnt = 2'd3;
         default: byte_cnt = 2'd1;
      endcase
   end

   always_comb begin
      p_byte = cur_status;
`ifdef MEM_WRITER_BFLAG_EN
      p_byte[5] = 1'b1;
      p_byte[4] = cur_brk;
`endif
   end

   always_comb begin
      // Stack grows down one byte per push, wrapping within the page.
      push_sp = cur_sp - REG_WIDTH'(byte_idx);
      if (cur_mode == 2'b00) begin
         byte_addr = cur_addr;
      end else begin
         byte_addr = STACK_BASE | ADDR_WIDTH'(push_sp);
      end
      case ({cur_mode, byte_idx})
         {2'b10, 2'd0}, {2'b11, 2'd0}: byte_data = REG_WIDTH'(cur_word[15:8]);
         {2'b10, 2'd1}, {2'b11, 2'd1}: byte_data = REG_WIDTH'(cur_word[7:0]);
         {2'b11, 2'd2}:                byte_data = p_byte;
         default:                      byte_data = cur_data;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      addr_d     = addr_q;
      data_d     = data_q;
      word_d     = word_q;
      status_d   = status_q;
      sp_d       = sp_q;
      addr_out_d = addr_out_q;
      data_out_d = data_out_q;
      we_mem_d   = 1'b0;
      sp_out_d   = sp_out_q;
      we_sp_d    = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               mode_d     = mode;
               addr_d     = addr_in;
               data_d     = data_in;
               word_d     = word_in;
               status_d   = status_in;
               sp_d       = sp_in;
               state_d    = StWr0;
               we_mem_d   = 1'b1;
               addr_out_d = byte_addr;
               data_out_d = byte_data;
            end
         end
         StWr0, StWr1, StWr2: begin
            if (byte_idx != 2'd0 && byte_idx < byte_cnt) begin
               state_d    = (state_q == StWr0) ? StWr1 : StWr2;
               we_mem_d   = 1'b1;
               addr_out_d = byte_addr;
               data_out_d = byte_data;
            end else begin
               state_d = StDone;
               done_d  = 1'b1;
               if (cur_mode != 2'b00) begin
                  we_sp_d  = 1'b1;
                  sp_out_d = cur_sp - REG_WIDTH'(byte_cnt);
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         mode_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         word_q     <= '0;
         status_q   <= '0;
         brk_q      <= 1'b0;
         sp_q       <= '0;
         addr_out_q <= '0;
         data_out_q <= '0;
         we_mem_q   <= 1'b0;
         sp_out_q   <= '0;
         we_sp_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         word_q     <= word_d;
         status_q   <= status_d;
         brk_q      <= brk_d;
         sp_q       <= sp_d;
         addr_out_q <= addr_out_d;
         data_out_q <= data_out_d;
         we_mem_q   <= we_mem_d;
         sp_out_q   <= sp_out_d;
         we_sp_q    <= we_sp_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign addr_out = addr_out_q;
   assign data_out = data_out_q;
   assign we_mem   = we_mem_q;
   assign sp_out   = sp_out_q;
   assign we_sp    = we_sp_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
